edit_input_ctrl: RTL and testbench

//   Front-end for time editing: turns two raw push-buttons (mode, adjust) into the

---
 rtl/clock_pkg.sv | 28 ++
 rtl/edit_input_ctrl_if.sv | 28 ++
 rtl/button_debounce.sv | 59 +++++
 rtl/edit_input_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_edit_input_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Encodings shared by the time-edit front-end: field select codes, adjust FSM states,
// button lane indices and the select-advance helper.
package clock_pkg;

    typedef enum logic [1:0] {
        SEL_RUN  = 2'd0,
        SEL_SEC  = 2'd1,
        SEL_MIN  = 2'd2,
        SEL_HOUR = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DELAY        = 2'd1,
        ST_REPEAT       = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } adj_state_e;

    localparam int NUM_BUTTONS = 2;
    localparam int BTN_MODE    = 0;
    localparam int BTN_ADJ     = 1;

    // Field order run -> sec -> min -> hour -> run; the carry out of bit 1 is the wrap.
    function automatic sel_e next_sel(input sel_e cur);
        return sel_e'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/edit_input_ctrl_if.sv
// Button inputs and edit controls of the time-edit front-end, bundled as one port.
interface edit_input_ctrl_if;
    import clock_pkg::*;

    logic btn_mode;
    logic btn_adj;
    sel_e select;
    logic increment;
    logic editing;

    // master: the side owning the buttons and consuming select/increment.
    modport master (
        output btn_mode,
        output btn_adj,
        input  select,
        input  increment,
        input  editing
    );

    modport slave (
        input  btn_mode,
        input  btn_adj,
        output select,
        output increment,
        output editing
    );

endinterface

// File: rtl/button_debounce.sv
// One push-button lane: 2-FF synchroniser, consecutive-sample debounce and a
// one-cycle rising-edge pulse aligned with the delayed debounced level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             level_reg;
    logic             level_next;
    logic             level_dly_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Count only while the synchronised input disagrees with the debounced level;
    // a single agreeing sample restarts the run.
    always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        if (sync_reg[1] != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = sync_reg[1];
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg      <= '0;
            level_reg     <= 1'b0;
            level_dly_reg <= 1'b0;
            press_reg     <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            sync_reg      <= {sync_reg[0], raw};
            level_reg     <= level_next;
            level_dly_reg <= level_reg;
            press_reg     <= level_reg & ~level_dly_reg;
            cnt_reg       <= cnt_next;
        end
    end

    // The delayed level rises in the same cycle as the press pulse, so consumers
    // see "pressed and held" together.
    assign level = level_dly_reg;
    assign press = press_reg;

endmodule

// File: rtl/edit_input_ctrl.sv
// Time-edit front-end: debounces mode/adjust buttons, cycles the edited field,
// issues increment pulses and returns to run mode after an idle timeout.
// Build option AUTO_REPEAT_EN enables hold-to-repeat increments.
module edit_input_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
`ifdef AUTO_REPEAT_EN
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 2,
`endif
    parameter int TIMEOUT_CYCLES  = 64
) (
    input logic              clk,
    input logic              reset,
    edit_input_ctrl_if.slave bus
);

    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] raw_btn;
    logic [NUM_BUTTONS-1:0] db_level;
    logic [NUM_BUTTONS-1:0] db_press;

    assign raw_btn[BTN_MODE] = bus.btn_mode;
    assign raw_btn[BTN_ADJ]  = bus.btn_adj;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_btn[gi]),
            .level (db_level[gi]),
            .press (db_press[gi])
        );
    end

    logic mode_press;
    logic adj_press;
    logic adj_level;
    logic unused_mode_level;

    assign mode_press        = db_press[BTN_MODE];
    assign adj_press         = db_press[BTN_ADJ];
    assign adj_level         = db_level[BTN_ADJ];
    // The mode button acts only on its press edge; its held level is not needed.
    assign unused_mode_level = db_level[BTN_MODE];

    adj_state_e       state_reg;
    adj_state_e       state_next;
    sel_e             sel_reg;
    sel_e             sel_next;
    logic             inc_reg;
    logic             inc_next;
    logic             editing_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [TMO_W-1:0] tmo_next;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_reg;
    logic [RPT_W-1:0] rpt_cnt_next;
`endif

    always_comb begin
        state_next = state_reg;
        inc_next   = 1'b0;
        sel_next   = sel_reg;
        tmo_next   = tmo_cnt_reg;
`ifdef AUTO_REPEAT_EN
        rpt_cnt_next = rpt_cnt_reg;
`endif

        // Releasing adjust always returns to IDLE, whatever the state.
        if (!adj_level) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (adj_press) begin
                        if (sel_reg != SEL_RUN) begin
                            inc_next = 1'b1;
`ifdef AUTO_REPEAT_EN
                            state_next   = ST_DELAY;
                            rpt_cnt_next = '0;
`else
                            state_next = ST_WAIT_RELEASE;
`endif
                        end else begin
                            state_next = ST_WAIT_RELEASE;
                        end
                    end
                end
`ifdef AUTO_REPEAT_EN
                ST_DELAY: begin
                    if (rpt_cnt_reg == DELAY_LAST) begin
                        inc_next     = 1'b1;
                        state_next   = ST_REPEAT;
                        rpt_cnt_next = '0;
                    end else begin
                        rpt_cnt_next = rpt_cnt_reg + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (rpt_cnt_reg == PERIOD_LAST) begin
                        inc_next     = 1'b1;
                        rpt_cnt_next = '0;
                    end else begin
                        rpt_cnt_next = rpt_cnt_reg + 1'b1;
                    end
                end
`endif
                ST_WAIT_RELEASE: state_next = ST_WAIT_RELEASE;
                default:         state_next = ST_IDLE;
            endcase
        end

        // Mode outranks adjust: a coincident adjust press is swallowed and the
        // button must be released before it can increment again.
        if (mode_press) begin
            sel_next = next_sel(sel_reg);
            inc_next = 1'b0;
            if (adj_level) begin
                state_next = ST_WAIT_RELEASE;
            end
        end

        // Any user activity restarts the idle window; activity on the last idle
        // cycle therefore still keeps the field selected.
        if (sel_reg == SEL_RUN || mode_press || adj_press || inc_next) begin
            tmo_next = '0;
        end else if (tmo_cnt_reg == TMO_LAST) begin
            sel_next = SEL_RUN;
            tmo_next = '0;
            if (adj_level) begin
                state_next = ST_WAIT_RELEASE;
            end
        end else begin
            tmo_next = tmo_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= SEL_RUN;
            inc_reg     <= 1'b0;
            editing_reg <= 1'b0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            inc_reg     <= inc_next;
            editing_reg <= (sel_next != SEL_RUN);
            tmo_cnt_reg <= tmo_next;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt_reg <= '0;
        end else begin
            rpt_cnt_reg <= rpt_cnt_next;
        end
    end
`endif

    assign bus.select    = sel_reg;
    assign bus.increment = inc_reg;
    assign bus.editing   = editing_reg;

endmodule

// File: tb/tb_edit_input_ctrl.sv
// Bench for edit_input_ctrl: scenario tasks drive buttons and check select/editing inline;
// increment pulses are matched against a queue of expected cycle numbers.
module tb_edit_input_ctrl;
    import clock_pkg::*;

    localparam int DEB     = 4;
    // Drive just after edge n: output changes visibly in cycle n + DEB + 4.
    localparam int OUT_LAT = DEB + 4;
    localparam int TMO     = 64;
`ifdef AUTO_REPEAT_EN
    localparam int RD = 8;
    localparam int RP = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_inc_q[$];
    int   mon_exp;

    edit_input_ctrl_if bus ();

    edit_input_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        tick(10);
        bus.btn_mode = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_cmp++;
        if (bus.select !== SEL_RUN) begin
            n_mis++; $display("FAIL reset_select got=%0d exp=0", bus.select);
        end
        n_cmp++;
        if (bus.increment !== 1'b0) begin
            n_mis++; $display("FAIL reset_increment got=%b exp=0", bus.increment);
        end
        n_cmp++;
        if (bus.editing !== 1'b0) begin
            n_mis++; $display("FAIL reset_editing got=%b exp=0", bus.editing);
        end
        reset = 1'b0;
        tick(5);
        // Three high samples is one short of the debounce run.
        bus.btn_mode = 1'b1;
        tick(3);
        bus.btn_mode = 1'b0;
        tick(20);
        n_cmp++;
        if (bus.select !== SEL_RUN) begin
            n_mis++; $display("FAIL glitch_select got=%0d exp=0", bus.select);
        end
        n_cmp++;
        if (bus.editing !== 1'b0) begin
            n_mis++; $display("FAIL glitch_editing got=%b exp=0", bus.editing);
        end
        $display("[%0d] test_reset: glitch ignored, select=%0d", cyc, bus.select);
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_sel;
        logic [1:0] prev_sel;
        exp_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            prev_sel = exp_sel;
            exp_sel  = exp_sel + 2'd1;
            bus.btn_mode = 1'b1;
            tick(OUT_LAT - 1);
            n_cmp++;
            if (bus.select !== prev_sel) begin
                n_mis++; $display("FAIL mode_early got=%0d exp=%0d", bus.select, prev_sel);
            end
            tick(1);
            n_cmp++;
            if (bus.select !== exp_sel) begin
                n_mis++; $display("FAIL mode_select got=%0d exp=%0d", bus.select, exp_sel);
            end
            n_cmp++;
            if (bus.editing !== (exp_sel != 2'd0)) begin
                n_mis++; $display("FAIL mode_editing got=%b exp=%b", bus.editing, exp_sel != 2'd0);
            end
            tick(10 - OUT_LAT);
            bus.btn_mode = 1'b0;
            tick(10);
            $display("[%0d] test_mode_cycle: press %0d select=%0d editing=%b", cyc, i, bus.select, bus.editing);
        end
    endtask

    task automatic test_auto_repeat();
        int m;
        press_mode();
        n_cmp++;
        if (bus.select !== SEL_SEC) begin
            n_mis++; $display("FAIL repeat_setup got=%0d exp=1", bus.select);
        end
        m = cyc;
        bus.btn_adj = 1'b1;
        exp_inc_q.push_back(m + OUT_LAT);
`ifdef AUTO_REPEAT_EN
        for (int t = OUT_LAT + RD; t <= OUT_LAT + 20; t += RP) begin
            exp_inc_q.push_back(m + t);
        end
`endif
        tick(22);
        bus.btn_adj = 1'b0;
        tick(20);
        n_cmp++;
        if (exp_inc_q.size() != 0) begin
            n_mis++; $display("FAIL repeat_missing got=%0d pending exp=0", exp_inc_q.size());
        end
        n_cmp++;
        if (bus.select !== SEL_SEC) begin
            n_mis++; $display("FAIL repeat_select got=%0d exp=1", bus.select);
        end
        $display("[%0d] test_auto_repeat: adj held from cycle %0d", cyc, m);
    endtask

    task automatic test_adj_run();
        press_mode();
        press_mode();
        press_mode();
        n_cmp++;
        if (bus.select !== SEL_RUN) begin
            n_mis++; $display("FAIL adjrun_setup got=%0d exp=0", bus.select);
        end
        bus.btn_adj = 1'b1;
        tick(10);
        bus.btn_adj = 1'b0;
        tick(20);
        n_cmp++;
        if (bus.select !== SEL_RUN) begin
            n_mis++; $display("FAIL adjrun_select got=%0d exp=0", bus.select);
        end
        n_cmp++;
        if (bus.editing !== 1'b0) begin
            n_mis++; $display("FAIL adjrun_editing got=%b exp=0", bus.editing);
        end
        $display("[%0d] test_adj_run: adj in run mode, select=%0d", cyc, bus.select);
    endtask

    task automatic test_timeout();
        int n;
        int s;
        int m;
        press_mode();
        n = cyc;
        press_mode();
        s = n + OUT_LAT;
        tick(s + TMO - 1 - cyc);
        n_cmp++;
        if (bus.select !== SEL_MIN) begin
            n_mis++; $display("FAIL tmo_before got=%0d exp=2", bus.select);
        end
        tick(1);
        n_cmp++;
        if (bus.select !== SEL_RUN) begin
            n_mis++; $display("FAIL tmo_expire got=%0d exp=0", bus.select);
        end
        n_cmp++;
        if (bus.editing !== 1'b0) begin
            n_mis++; $display("FAIL tmo_editing got=%b exp=0", bus.editing);
        end
        $display("[%0d] test_timeout: idle expiry, select=%0d", cyc, bus.select);

        press_mode();
        n = cyc;
        press_mode();
        s = n + OUT_LAT;
        // Adjust press edge lands on the last idle cycle.
        tick(s + TMO - OUT_LAT - cyc);
        m = cyc;
        bus.btn_adj = 1'b1;
        exp_inc_q.push_back(m + OUT_LAT);
        tick(6);
        bus.btn_adj = 1'b0;
        tick(s + TMO - cyc);
        n_cmp++;
        if (bus.select !== SEL_MIN) begin
            n_mis++; $display("FAIL tmo_saved got=%0d exp=2", bus.select);
        end
        tick(TMO - 1);
        n_cmp++;
        if (bus.select !== SEL_MIN) begin
            n_mis++; $display("FAIL tmo_restart_before got=%0d exp=2", bus.select);
        end
        tick(1);
        n_cmp++;
        if (bus.select !== SEL_RUN) begin
            n_mis++; $display("FAIL tmo_restart_expire got=%0d exp=0", bus.select);
        end
        n_cmp++;
        if (exp_inc_q.size() != 0) begin
            n_mis++; $display("FAIL tmo_pulse_missing got=%0d pending exp=0", exp_inc_q.size());
        end
        $display("[%0d] test_timeout: last-cycle press restarted window", cyc);
    endtask

    task automatic test_simultaneous();
        int m;
        press_mode();
        m = cyc;
        bus.btn_mode = 1'b1;
        bus.btn_adj  = 1'b1;
        tick(OUT_LAT);
        n_cmp++;
        if (bus.select !== SEL_MIN) begin
            n_mis++; $display("FAIL simul_select got=%0d exp=2", bus.select);
        end
        n_cmp++;
        if (bus.editing !== 1'b1) begin
            n_mis++; $display("FAIL simul_editing got=%b exp=1", bus.editing);
        end
        tick(10 - OUT_LAT);
        bus.btn_mode = 1'b0;
        tick(10);
        bus.btn_adj = 1'b0;
        tick(15);
        m = cyc;
        bus.btn_adj = 1'b1;
        exp_inc_q.push_back(m + OUT_LAT);
        tick(6);
        bus.btn_adj = 1'b0;
        tick(15);
        n_cmp++;
        if (exp_inc_q.size() != 0) begin
            n_mis++; $display("FAIL simul_repress got=%0d pending exp=0", exp_inc_q.size());
        end
        n_cmp++;
        if (bus.select !== SEL_MIN) begin
            n_mis++; $display("FAIL simul_final got=%0d exp=2", bus.select);
        end
        $display("[%0d] test_simultaneous: mode won, re-press pulsed once", cyc);
    endtask

    task automatic test_reset_mid_press();
        bus.btn_mode = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(2);
        n_cmp++;
        if (bus.select !== SEL_RUN) begin
            n_mis++; $display("FAIL midrst_reset got=%0d exp=0", bus.select);
        end
        reset = 1'b0;
        tick(OUT_LAT - 1);
        n_cmp++;
        if (bus.select !== SEL_RUN) begin
            n_mis++; $display("FAIL midrst_early got=%0d exp=0", bus.select);
        end
        tick(1);
        n_cmp++;
        if (bus.select !== SEL_SEC) begin
            n_mis++; $display("FAIL midrst_press got=%0d exp=1", bus.select);
        end
        bus.btn_mode = 1'b0;
        tick(20);
        $display("[%0d] test_reset_mid_press: held button seen as press, select=%0d", cyc, bus.select);
    endtask

    initial begin
        reset        = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_adj  = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (reset === 1'b0 && bus.increment !== 1'b0) begin
                    n_cmp++;
                    if (exp_inc_q.size() == 0) begin
                        n_mis++;
                        $display("FAIL inc_unexpected at cycle=%0d exp=no pulse", cyc);
                    end else begin
                        mon_exp = exp_inc_q.pop_front();
                        if (cyc !== mon_exp) begin
                            n_mis++;
                            $display("FAIL inc_cycle got=%0d exp=%0d", cyc, mon_exp);
                        end else begin
                            $display("[%0d] increment pulse", cyc);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_mode_cycle();
        test_auto_repeat();
        test_adj_run();
        test_timeout();
        test_simultaneous();
        test_reset_mid_press();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
